// File: rtl/verifier_compute_mlext_dot_pkg.sv
// Shared field constants and FSM encoding for the multilinear-extension dot
// product evaluator.
//   F_NBITS : width of one field element
//   F_Q     : field modulus, the Mersenne prime 2^61 - 1
//   state_t : controller states of verifier_compute_mlext_dot
//   mersenne_reduce : fully reduces a double-width product modulo F_Q
package verifier_compute_mlext_dot_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q = 61'h1FFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_ST,
    ST_MUL,
    ST_ADD_ST,
    ST_ADD
  } state_t;

  // 2^61 == 1 mod q, so the high half folds onto the low half. Two folds
  // bring the value to at most 2^61, and one conditional subtract finishes.
  function automatic logic [F_NBITS-1:0] mersenne_reduce(input logic [2*F_NBITS-1:0] p);
    logic [F_NBITS:0] s0;
    logic [F_NBITS:0] s1;
    s0 = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
    s1 = {1'b0, s0[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, s0[F_NBITS]};
    if (s1 >= {1'b0, F_Q}) begin
      s1 = s1 - {1'b0, F_Q};
    end
    return s1[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/verifier_compute_mlext_dot_field.sv
// Field arithmetic units used by verifier_compute_mlext_dot.
//
// field_multiplier: c = a*b mod q, three cycles enable-to-ready.
//   clk, rstb : clock, asynchronous active-low reset
//   en        : one-cycle start, operands sampled on this cycle
//   a, b      : reduced operands
//   c         : reduced product, valid while ready is high after a run
//   ready     : idle and no start this cycle
//
// field_adder: c = a+b mod q, one cycle enable-to-ready.
//   same port meaning as field_multiplier
module field_multiplier
  import verifier_compute_mlext_dot_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);

  logic [F_NBITS-1:0]   a_r;
  logic [F_NBITS-1:0]   b_r;
  logic [2*F_NBITS-1:0] prod_r;
  logic                 v1;
  logic                 v2;
  logic                 idle;

  assign idle  = ~v1 & ~v2;
  assign ready = idle & ~en;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_r    <= '0;
      b_r    <= '0;
      prod_r <= '0;
      c      <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
    end else begin
      v1 <= en & idle;
      v2 <= v1;
      if (en && idle) begin
        a_r <= a;
        b_r <= b;
      end
      if (v1) begin
        prod_r <= {{F_NBITS{1'b0}}, a_r} * {{F_NBITS{1'b0}}, b_r};
      end
      if (v2) begin
        c <= mersenne_reduce(prod_r);
      end
    end
  end

endmodule

module field_adder
  import verifier_compute_mlext_dot_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic [F_NBITS-1:0] c,
  output logic               ready
);

  logic [F_NBITS:0] sum;
  logic [F_NBITS:0] sum_red;

  assign ready = ~en;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    sum_red = sum;
    if (sum >= {1'b0, F_Q}) begin
      sum_red = sum - {1'b0, F_Q};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      c <= '0;
    end else if (en) begin
      c <= sum_red[F_NBITS-1:0];
    end
  end

endmodule

// File: rtl/verifier_compute_mlext_dot.sv
// Sequential multilinear-extension evaluator: result = sum_i chi_i * v_i mod q
// using one time-shared field multiplier and one field adder.
//   clk     : clock
//   rstb    : asynchronous active-low reset
//   en      : start request, a rising edge starts one run
//   early   : sampled at start, limits the sum to the first 2^nEarlyBits entries
//   chi_in  : nValues packed chi weights, entry i at [i*F_NBITS +: F_NBITS]
//   vals_in : nValues packed values, same layout
//   result  : reduced dot product, updated once at the end of each run
//   ready   : idle with no start pending this cycle
module verifier_compute_mlext_dot
  import verifier_compute_mlext_dot_pkg::*;
#(
  parameter int nValBits   = 8,
  parameter int nEarlyBits = nValBits,
  parameter int nValues    = 1 << nValBits
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       en,
  input  logic                       early,
  input  logic [nValues*F_NBITS-1:0] chi_in,
  input  logic [nValues*F_NBITS-1:0] vals_in,
  output logic [F_NBITS-1:0]         result,
  output logic                       ready
);

  if (nValues != (1 << nValBits)) begin : g_bad_nvalues
    $error("nValues is derived from nValBits and must not be overridden");
  end
  if (nEarlyBits > nValBits) begin : g_bad_nearly
    $error("nEarlyBits must not exceed nValBits");
  end

  localparam int LAST_EARLY_I = (1 << nEarlyBits) - 1;
  localparam logic [nValBits-1:0] LAST_EARLY = LAST_EARLY_I[nValBits-1:0];
  localparam logic [nValBits-1:0] LAST_FULL  = '1;

  state_t               state, state_nxt;
  logic [nValBits-1:0]  idx, idx_nxt;
  logic [nValBits-1:0]  last, last_nxt;
  logic                 first, first_nxt;
  logic [F_NBITS-1:0]   acc, acc_nxt;
  logic [F_NBITS-1:0]   result_nxt;
  logic                 en_dly;
  logic                 start;
  logic                 elem_done;

  logic                 mul_en, mul_ready, add_en, add_ready;
  logic [F_NBITS-1:0]   mul_a, mul_b, mul_c, add_c;

  assign start  = en & ~en_dly;
  assign ready  = (state == ST_IDLE) & ~start;
  assign mul_en = (state == ST_MUL_ST);
  assign add_en = (state == ST_ADD_ST);
  assign mul_a  = chi_in[int'(idx)*F_NBITS +: F_NBITS];
  assign mul_b  = vals_in[int'(idx)*F_NBITS +: F_NBITS];

  field_multiplier u_mul (
    .clk   (clk),
    .rstb  (rstb),
    .en    (mul_en),
    .a     (mul_a),
    .b     (mul_b),
    .c     (mul_c),
    .ready (mul_ready)
  );

  // The adder reads the product straight from the multiplier output, which
  // holds until the next multiply is issued.
  field_adder u_add (
    .clk   (clk),
    .rstb  (rstb),
    .en    (add_en),
    .a     (acc),
    .b     (mul_c),
    .c     (add_c),
    .ready (add_ready)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= ST_IDLE;
      idx    <= '0;
      last   <= '0;
      first  <= 1'b0;
      acc    <= '0;
      result <= '0;
      en_dly <= 1'b1;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      last   <= last_nxt;
      first  <= first_nxt;
      acc    <= acc_nxt;
      result <= result_nxt;
      en_dly <= en;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    last_nxt   = last;
    first_nxt  = first;
    acc_nxt    = acc;
    result_nxt = result;
    elem_done  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          last_nxt  = early ? LAST_EARLY : LAST_FULL;
          first_nxt = 1'b1;
          state_nxt = ST_MUL_ST;
        end
      end
      ST_MUL_ST, ST_MUL: begin
        state_nxt = ST_MUL;
        if (mul_ready) begin
          if (first) begin
            acc_nxt   = mul_c;
            first_nxt = 1'b0;
            elem_done = 1'b1;
          end else begin
            state_nxt = ST_ADD_ST;
          end
        end
      end
      ST_ADD_ST, ST_ADD: begin
        state_nxt = ST_ADD;
        if (add_ready) begin
          acc_nxt   = add_c;
          elem_done = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Shared tail of both accumulate paths: publish on the last entry,
    // otherwise issue the next multiply.
    if (elem_done) begin
      if (idx == last) begin
        result_nxt = acc_nxt;
        state_nxt  = ST_IDLE;
      end else begin
        idx_nxt   = idx + 1'b1;
        state_nxt = ST_MUL_ST;
      end
    end
  end

endmodule

// File: tb/tb_verifier_compute_mlext_dot.sv
// Directed testbench for verifier_compute_mlext_dot: a small 8-entry instance
// (nEarlyBits=1) for hand-computed vectors and control behaviour, and a
// 256-entry instance (nEarlyBits=0) against a modular-arithmetic model.
module tb_verifier_compute_mlext_dot;

  localparam int NB = 61;
  localparam logic [NB-1:0] Q = 61'h1FFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic en_a = 1'b0, early_a = 1'b0, en_b = 1'b0, early_b = 1'b0;
  logic [NB-1:0] chi_av [8];
  logic [NB-1:0] val_av [8];
  logic [NB-1:0] chi_bv [256];
  logic [NB-1:0] val_bv [256];
  logic [8*NB-1:0]   chi_a, vals_a;
  logic [256*NB-1:0] chi_b, vals_b;
  logic [NB-1:0] result_a, result_b;
  logic ready_a, ready_b;

  for (genvar i = 0; i < 8; i++) begin : g_pack_a
    assign chi_a[i*NB +: NB]  = chi_av[i];
    assign vals_a[i*NB +: NB] = val_av[i];
  end
  for (genvar i = 0; i < 256; i++) begin : g_pack_b
    assign chi_b[i*NB +: NB]  = chi_bv[i];
    assign vals_b[i*NB +: NB] = val_bv[i];
  end

  verifier_compute_mlext_dot #(.nValBits(3), .nEarlyBits(1)) dut_a (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en_a),
    .early   (early_a),
    .chi_in  (chi_a),
    .vals_in (vals_a),
    .result  (result_a),
    .ready   (ready_a)
  );

  verifier_compute_mlext_dot #(.nValBits(8), .nEarlyBits(0)) dut_b (
    .clk     (clk),
    .rstb    (rstb),
    .en      (en_b),
    .early   (early_b),
    .chi_in  (chi_b),
    .vals_in (vals_b),
    .result  (result_b),
    .ready   (ready_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [NB-1:0] mmul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [127:0] p;
    p = {67'd0, a} * {67'd0, b};
    p = p % {67'd0, Q};
    return p[NB-1:0];
  endfunction

  function automatic logic [NB-1:0] madd(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [63:0] s;
    s = ({3'd0, a} + {3'd0, b}) % {3'd0, Q};
    return s[NB-1:0];
  endfunction

  function automatic logic [NB-1:0] rnd_elem();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r = r % {3'd0, Q};
    return r[NB-1:0];
  endfunction

  // One run on the small instance; counts cycles with ready low from the
  // start cycle onward and watches result for premature changes.
  task automatic run_a(input logic e, input logic [NB-1:0] exp_res, input int exp_lat,
                       input string tag);
    int lat, changed;
    bit done;
    logic [NB-1:0] prev;
    changed = 0;
    done = 1'b0;
    @(negedge clk);
    early_a = e;
    en_a = 1'b1;
    #1;
    lat = ready_a ? 0 : 1;
    prev = result_a;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      en_a = 1'b0;
      #1;
      if (ready_a) done = 1'b1;
      else begin
        lat++;
        if (result_a !== prev) changed++;
      end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_result"}, 64'(result_a), 64'(exp_res));
    check({tag, "_stable"}, 64'(changed), 64'd0);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // Issues a start on the large instance immediately (back-to-back use).
  task automatic run_b(input logic e, input logic [NB-1:0] exp_res, input string tag);
    bit done;
    done = 1'b0;
    early_b = e;
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      #1;
      if (ready_b) done = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_result"}, 64'(result_b), 64'(exp_res));
  endtask

  initial begin
    int lows, rises, changed;
    bit done, prev_rdy;
    logic [NB-1:0] model;

    for (int i = 0; i < 8; i++) begin
      chi_av[i] = '0;
      val_av[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      chi_bv[i] = '0;
      val_bv[i] = '0;
    end

    // en already high across reset must not start a run
    en_a = 1'b1;
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    #1;
    check("rst_result_a", 64'(result_a), 64'd0);
    check("rst_ready_a", 64'(ready_a), 64'd1);
    check("rst_result_b", 64'(result_b), 64'd0);
    check("rst_ready_b", 64'(ready_b), 64'd1);
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (!ready_a) lows++;
    end
    check("en_through_reset_no_run", 64'(lows), 64'd0);
    en_a = 1'b0;

    // 1*5 + 2*6 + 3*7 + 4*8 = 70
    for (int i = 0; i < 8; i++) begin
      chi_av[i] = (i < 4) ? NB'(i + 1) : '0;
      val_av[i] = NB'(i + 5);
    end
    run_a(1'b0, 61'd70, 47, "dot4");

    // (q-1)*2 = 2q-2 == q-2
    for (int i = 0; i < 8; i++) begin
      chi_av[i] = '0;
      val_av[i] = NB'(123 + i);
    end
    chi_av[0] = Q - 61'd1;
    val_av[0] = 61'd2;
    run_a(1'b0, Q - 61'd2, 47, "wrap");

    // early: 1+2 = 3; full: 1+..+8 = 36
    for (int i = 0; i < 8; i++) begin
      chi_av[i] = 61'd1;
      val_av[i] = NB'(i + 1);
    end
    run_a(1'b1, 61'd3, 11, "early");
    run_a(1'b0, 61'd36, 47, "full");

    // en held high: 2+..+9 = 44, exactly one run
    for (int i = 0; i < 8; i++) val_av[i] = NB'(i + 2);
    @(negedge clk);
    early_a = 1'b0;
    en_a = 1'b1;
    rises = 0;
    lows = 0;
    prev_rdy = 1'b1;
    repeat (150) begin
      #1;
      if (!ready_a) lows++;
      if (ready_a && !prev_rdy) rises++;
      prev_rdy = ready_a;
      @(negedge clk);
    end
    check("hold_runs", 64'(rises), 64'd1);
    check("hold_busy_cycles", 64'(lows), 64'd47);
    check("hold_result", 64'(result_a), 64'd44);
    en_a = 1'b0;

    // en re-pulsed mid-run is ignored; result holds 44 until the run ends
    for (int i = 0; i < 8; i++) val_av[i] = NB'(i + 1);
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (9) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    changed = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (ready_a) done = 1'b1;
      else begin
        if (result_a !== 61'd44) changed++;
        @(negedge clk);
      end
    end
    check("mid_en_done", 64'(done), 64'd1);
    check("mid_en_stable", 64'(changed), 64'd0);
    check("mid_en_result", 64'(result_a), 64'd36);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (!ready_a) lows++;
    end
    check("mid_en_no_second_run", 64'(lows), 64'd0);

    // reset mid-run, en high through reset; then 3+..+10 = 52 afterwards
    for (int i = 0; i < 8; i++) val_av[i] = NB'(i + 3);
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (10) @(negedge clk);
    rstb = 1'b0;
    en_a = 1'b1;
    #1;
    check("rst_mid_result_async", 64'(result_a), 64'd0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_ready", 64'(ready_a), 64'd1);
    check("rst_mid_result", 64'(result_a), 64'd0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (!ready_a) lows++;
    end
    check("rst_mid_no_run", 64'(lows), 64'd0);
    en_a = 1'b0;
    run_a(1'b0, 61'd52, 47, "after_reset");

    // large instance: single-entry early runs and full random runs
    @(negedge clk);
    #1;
    for (int r = 0; r < 10; r++) begin
      chi_bv[0] = rnd_elem();
      val_bv[0] = rnd_elem();
      chi_bv[1] = rnd_elem();
      val_bv[1] = rnd_elem();
      run_b(1'b1, mmul(chi_bv[0], val_bv[0]), $sformatf("b_early%0d", r));
    end
    for (int r = 0; r < 6; r++) begin
      model = '0;
      for (int i = 0; i < 256; i++) begin
        chi_bv[i] = rnd_elem();
        val_bv[i] = rnd_elem();
        model = madd(model, mmul(chi_bv[i], val_bv[i]));
      end
      run_b(1'b0, model, $sformatf("b_full%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
